// File: rtl/if_id_buffer.sv
// if_id_buffer: DEPTH-entry instruction FIFO between the I-cache and decode, presenting
// the head as Instr/PC_ID plus decoded fields. Optional IF_ID_PERF_EN adds stall/flush counters.
module if_id_buffer #(
  parameter int          DEPTH    = 2,            // 2 or 4 (power of two, pointers wrap naturally)
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        ic_valid,
  input  logic [31:0] ic_instr,
  input  logic [31:0] ic_pc,
  output logic        ic_ready,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] Instr,
  output logic [31:0] PC_ID,
  output logic [4:0]  Opcode,
  output logic [2:0]  Funct3,
  output logic [6:0]  Funct7,
  output logic        NOP_Ins,
  output logic        i_cache_en
`ifdef IF_ID_PERF_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [31:0]      r_instr_mem [DEPTH];
  logic [31:0]      r_pc_mem    [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_empty;
  logic w_push;
  logic w_pop;

  // Handshakes: a word transfers from the cache when ic_valid && ic_ready at a rising edge;
  // the head transfers to decode when i_cache_en && !stall. ic_ready and i_cache_en come
  // from registered state only, and flush cancels both transfers in its cycle.
  assign w_empty    = (r_count == '0);
  assign ic_ready   = (r_count < CNT_FULL);
  assign i_cache_en = !w_empty;
  assign w_push     = ic_valid && ic_ready && !flush;
  assign w_pop      = i_cache_en && !stall && !flush;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset: the count alone decides what is valid.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_instr_mem[r_wr_ptr] <= ic_instr;
      r_pc_mem[r_wr_ptr]    <= ic_pc;
    end
  end

  assign Instr   = w_empty ? NOP_WORD : r_instr_mem[r_rd_ptr];
  assign PC_ID   = w_empty ? 32'h0    : r_pc_mem[r_rd_ptr];
  assign Opcode  = Instr[6:2];
  assign Funct3  = Instr[14:12];
  assign Funct7  = Instr[31:25];
  assign NOP_Ins = w_empty || (Instr == NOP_WORD);

`ifdef IF_ID_PERF_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  // Both counters saturate rather than wrap so a long run never reads as a short one.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (i_cache_en && stall && !flush && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
      if (flush && !w_empty && (r_flush_cnt != 16'hFFFF))
        r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Bench for if_id_buffer: queue-based reference model, per-cycle compare process,
// directed scenarios with literal expectations, then randomized traffic.
module tb_if_id_buffer;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        ic_valid = 1'b0;
  logic [31:0] ic_instr = '0;
  logic [31:0] ic_pc = '0;
  logic        ic_ready;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] Instr;
  logic [31:0] PC_ID;
  logic [4:0]  Opcode;
  logic [2:0]  Funct3;
  logic [6:0]  Funct7;
  logic        NOP_Ins;
  logic        i_cache_en;
`ifdef IF_ID_PERF_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  if_id_buffer #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .CLK(CLK), .rst(rst), .ic_valid(ic_valid), .ic_instr(ic_instr), .ic_pc(ic_pc),
    .ic_ready(ic_ready), .stall(stall), .flush(flush), .Instr(Instr), .PC_ID(PC_ID),
    .Opcode(Opcode), .Funct3(Funct3), .Funct7(Funct7), .NOP_Ins(NOP_Ins),
    .i_cache_en(i_cache_en)
`ifdef IF_ID_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // reference model: queue of {pc, instr}, oldest at the front
  logic [63:0] exp_q[$];
  int unsigned m_stall_cnt = 0;
  int unsigned m_flush_cnt = 0;
  int n_vec = 0;
  int n_err = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_stall_cnt = 0;
    m_flush_cnt = 0;
  endtask

  // Applied at each rising edge with the inputs that were stable across it.
  task automatic model_edge();
    bit has_room, push, pop;
    if (rst) begin
      model_reset();
      return;
    end
    has_room = (exp_q.size() < DEPTH);
    push = ic_valid && has_room && !flush;
    pop  = (exp_q.size() > 0) && !stall && !flush;
    if (exp_q.size() > 0 && stall && !flush && m_stall_cnt < 16'hFFFF) m_stall_cnt++;
    if (flush && exp_q.size() > 0 && m_flush_cnt < 16'hFFFF) m_flush_cnt++;
    if (flush) exp_q.delete();
    else begin
      if (pop)  void'(exp_q.pop_front());
      if (push) exp_q.push_back({ic_pc, ic_instr});
    end
  endtask

  // compare process: outputs depend only on registered state, checked mid-cycle
  always @(negedge CLK) begin
    logic [31:0] e_instr, e_pc;
    bit e_valid;
    e_valid = (exp_q.size() > 0);
    e_instr = e_valid ? exp_q[0][31:0]  : NOP;
    e_pc    = e_valid ? exp_q[0][63:32] : 32'h0;
    cmp("i_cache_en", 32'(i_cache_en), 32'(e_valid));
    cmp("Instr", Instr, e_instr);
    cmp("PC_ID", PC_ID, e_pc);
    cmp("Opcode", 32'(Opcode), 32'(e_instr[6:2]));
    cmp("Funct3", 32'(Funct3), 32'(e_instr[14:12]));
    cmp("Funct7", 32'(Funct7), 32'(e_instr[31:25]));
    cmp("NOP_Ins", 32'(NOP_Ins), 32'(!e_valid || e_instr == NOP));
    cmp("ic_ready", 32'(ic_ready), 32'(exp_q.size() < DEPTH));
`ifdef IF_ID_PERF_EN
    cmp("stall_cnt", 32'(stall_cnt), m_stall_cnt);
    cmp("flush_cnt", 32'(flush_cnt), m_flush_cnt);
`endif
  end

  // driver: inputs change at the falling edge, model advances at the rising edge,
  // returning 1 time unit after that edge so callers can check literals
  task automatic cycle(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit st, input bit fl);
    @(negedge CLK);
    ic_valid = v; ic_instr = ins; ic_pc = pc; stall = st; flush = fl;
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    rst = 1'b1; ic_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] ri;
    bit rv, rs, rf;
    @(negedge CLK);
    rst = 1'b0;
    #1;
    cmp("rst_i_cache_en", 32'(i_cache_en), 32'd0);
    cmp("rst_Instr", Instr, 32'h00000013);
    cmp("rst_NOP_Ins", 32'(NOP_Ins), 32'd1);
    cmp("rst_ic_ready", 32'(ic_ready), 32'd1);

    // back-to-back stream: one-cycle latency, one per cycle
    cycle(1, 32'h00500093, 32'h0, 0, 0);
    cmp("s1_Instr", Instr, 32'h00500093);
    cmp("s1_Opcode", 32'(Opcode), 32'(5'b00100));
    cmp("s1_Funct3", 32'(Funct3), 32'd0);
    cmp("s1_PC", PC_ID, 32'h0);
    cycle(1, 32'h00A00113, 32'h4, 0, 0);
    cmp("s2_Instr", Instr, 32'h00A00113);
    cmp("s2_PC", PC_ID, 32'h4);
    cycle(1, 32'h002081B3, 32'h8, 0, 0);
    cmp("s3_Instr", Instr, 32'h002081B3);
    cmp("s3_PC", PC_ID, 32'h8);
    cycle(0, 32'h0, 32'h0, 0, 0);
    cmp("s4_empty", 32'(i_cache_en), 32'd0);

    // stall 4 cycles with ic_valid high: fills to 2, head held
    cycle(1, 32'h11111111, 32'h10, 1, 0);
    cycle(1, 32'h22222222, 32'h14, 1, 0);
    cmp("st_ready_full", 32'(ic_ready), 32'd0);
    cycle(1, 32'h33333333, 32'h18, 1, 0);
    cycle(1, 32'h33333333, 32'h18, 1, 0);
    cmp("st_head", Instr, 32'h11111111);
    cmp("st_ready", 32'(ic_ready), 32'd0);
    // full with stall low: only the pop happens
    cycle(1, 32'h33333333, 32'h18, 0, 0);
    cmp("rel_head", Instr, 32'h22222222);
    cmp("rel_ready", 32'(ic_ready), 32'd1);
    cycle(1, 32'h33333333, 32'h18, 0, 0);
    cmp("rel_head2", Instr, 32'h33333333);
    cmp("rel_pc2", PC_ID, 32'h18);
    cycle(0, 32'h0, 32'h0, 0, 0);
    cmp("rel_empty", 32'(i_cache_en), 32'd0);

    // flush with two entries and a waiting word; then with one entry and room
    cycle(1, 32'h44444444, 32'h20, 1, 0);
    cycle(1, 32'h55555555, 32'h24, 1, 0);
    cycle(1, 32'h66666666, 32'h28, 1, 1);
    cmp("fl_en", 32'(i_cache_en), 32'd0);
    cmp("fl_ready", 32'(ic_ready), 32'd1);
    cmp("fl_Instr", Instr, NOP);
    cycle(1, 32'h77777777, 32'h30, 1, 0);
    cycle(1, 32'h88888888, 32'h34, 0, 1);
    cycle(0, 32'h0, 32'h0, 0, 0);
    cmp("fl2_empty", 32'(i_cache_en), 32'd0);
    cycle(1, 32'h99999999, 32'h38, 0, 0);
    cmp("fl2_new", Instr, 32'h99999999);

    // asynchronous reset between edges
    cycle(1, 32'hAAAAAAAA, 32'h3C, 1, 0);
    #2 rst = 1'b1;
    model_reset();
    #1;
    cmp("arst_en", 32'(i_cache_en), 32'd0);
    cmp("arst_Instr", Instr, 32'h00000013);
    cmp("arst_ready", 32'(ic_ready), 32'd1);
    cycle(0, 32'h0, 32'h0, 0, 0);
    @(negedge CLK);
    rst = 1'b0;

`ifdef IF_ID_PERF_EN
    do_reset();
    cycle(1, 32'h00100093, 32'h0, 1, 0);
    for (int i = 0; i < 5; i++) cycle(0, 32'h0, 32'h0, 1, 0);
    cycle(0, 32'h0, 32'h0, 0, 1);
    cycle(1, 32'h00200093, 32'h4, 1, 0);
    cycle(0, 32'h0, 32'h0, 0, 1);
    cmp("perf_stall5", 32'(stall_cnt), 32'd5);
    cmp("perf_flush2", 32'(flush_cnt), 32'd2);
    cycle(1, 32'h00300093, 32'h8, 1, 0);
    for (int i = 0; i < 70000; i++) cycle(0, 32'h0, 32'h0, 1, 0);
    cmp("perf_sat", 32'(stall_cnt), 32'h0000FFFF);
    do_reset();
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rv = ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 3) == 0);
      rf = ($urandom_range(0, 31) == 0);
      ri = ($urandom_range(0, 7) == 0) ? NOP : $urandom;
      cycle(rv, ri, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, rs, rf);
    end

    @(negedge CLK);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_id_buffer.md
# if_id_buffer

Instruction buffer between the instruction cache and the decode-stage control unit. Holds up to DEPTH fetched instructions with their PCs in a small FIFO and presents the head entry to decode, split into Opcode/Funct3/Funct7 fields with a NOP_Ins flag and an i_cache_en valid. Absorbs decode stalls and hazard stalls without dropping fetches, and discards all buffered work on a branch/jump flush.

## Interface
- DEPTH, 2: buffer entries; legal values 2 or 4.
- NOP_WORD, 32'h00000013: canonical NOP (addi x0,x0,0) driven when the buffer is empty or flushed.

- CLK  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- ic_valid  in  1  cache presents a fetched word this cycle.
- ic_instr  in  32  fetched instruction.
- ic_pc  in  32  PC of ic_instr.
- ic_ready  out  1  buffer can accept a word this cycle.
- stall  in  1  decode/scoreboard cannot consume the head this cycle.
- flush  in  1  redirect from Branch/Jump resolution; discard all entries.
- Instr  out  32  head instruction, or NOP_WORD when empty.
- PC_ID  out  32  head PC; 0 when empty.
- Opcode  out  5  Instr[6:2].
- Funct3  out  3  Instr[14:12].
- Funct7  out  7  Instr[31:25].
- NOP_Ins  out  1  head is empty, or head equals NOP_WORD.
- i_cache_en  out  1  head entry valid for decode.

## Operation
- Storage: DEPTH-entry circular FIFO of {instr, pc}; write pointer, read pointer (log2(DEPTH) bits, wrap modulo DEPTH), count (log2(DEPTH)+1 bits).
- Push: ic_valid && ic_ready && !flush writes {ic_instr, ic_pc} at wr_ptr, wr_ptr++.
- Pop: i_cache_en && !stall && !flush advances rd_ptr.
- Push and pop in the same cycle: both occur, count unchanged.
- ic_ready = (count < DEPTH); depends only on registered state, no combinational path from stall or flush.
- Full: ic_ready low; ic_valid ignored; cache must hold its word.
- Empty: i_cache_en=0, Instr=NOP_WORD, PC_ID=0, NOP_Ins=1; pop suppressed.
- Flush: pointers and count cleared at next edge; same-cycle push and pop are both dropped; flush has priority over stall.
- Field outputs are pure slices of Instr; NOP_Ins=1 whenever i_cache_en=0 or Instr==NOP_WORD.
- Reset: pointers=0, count=0, storage contents don't-care; all outputs take empty values (Instr=NOP_WORD, PC_ID=0, NOP_Ins=1, i_cache_en=0, ic_ready=1).

## Timing
- Word pushed at edge N appears on Instr/i_cache_en in cycle N+1 (one-cycle fill latency).
- Sustained throughput 1 instruction/cycle with stall low and ic_valid high; no bubbles at DEPTH>=2.
- stall held k cycles: head outputs stable for k cycles; buffer fills to DEPTH, then ic_ready drops the cycle after count reaches DEPTH.
- Flush at edge N: i_cache_en=0 and ic_ready=1 from cycle N+1; first post-flush fetch pushed at edge N+1 at earliest, visible cycle N+2.
- rst asserted mid-operation: outputs go to reset values immediately (asynchronous), independent of CLK.

## Configuration
- IF_ID_PERF_EN defined: adds outputs stall_cnt (16 bits, counts cycles with i_cache_en && stall && !flush) and flush_cnt (16 bits, counts flush cycles with count>0); both saturate at 16'hFFFF, reset to 0.
- Undefined: counters and their ports absent; functional behaviour identical.

## Test plan
- Reset release, no ic_valid -> i_cache_en=0, Instr=32'h00000013, NOP_Ins=1, ic_ready=1.
- Stream 3 words (PC 0x0,0x4,0x8) back-to-back, stall=0 -> each on Instr exactly one cycle after push, consecutive cycles, PC_ID matches; Opcode of 32'h00500093 = 5'b00100, Funct3=0.
- stall=1 for 4 cycles while ic_valid=1, DEPTH=2 -> head unchanged, ic_ready drops after 2 pushes; release stall -> order preserved, no loss or duplicate.
- flush with 2 entries and simultaneous ic_valid -> next cycle i_cache_en=0, count=0, flushed-cycle word never appears.
- Simultaneous push/pop at full (count=DEPTH, stall=0) -> ic_ready=0 blocks push; only pop occurs, ic_ready=1 next cycle.
- With IF_ID_PERF_EN: 5 stalled valid cycles + 2 flushes of non-empty buffer -> stall_cnt=5, flush_cnt=2; forced 70000 stall cycles -> stall_cnt=16'hFFFF.
